// File: rtl/mem_stage.sv
// MIPS memory-access stage: resolves BEQ, runs LW/SW over a handshaked data-memory
// port with misalign/timeout aborts, and registers the MEM/WB write-back result.
module mem_stage #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [31:0]       target_in,
  input  logic              eq_in,
  input  logic [31:0]       alu_in,
  input  logic [31:0]       valB_in,
  input  logic [5:0]        dest_in,
  input  logic [5:0]        op_in,
  output logic              stall,
  output logic              pc_src,
  output logic [31:0]       branch_target,
  output logic              dm_req,
  output logic              dm_we,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [31:0]       dm_wdata,
  input  logic              dm_ready,
  input  logic              dm_rvalid,
  input  logic [31:0]       dm_rdata,
  output logic [31:0]       wb_data,
  output logic [5:0]        wb_dest,
  output logic              wb_valid,
  output logic              mem_fault
);

  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_SW  = 6'h2B;
  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic [31:0]   rdata_hold;
  logic          abort;

  logic is_mem;
  logic aligned;
  logic issue;
  logic timer_expired;

  assign is_mem        = (op_in == OP_LW) || (op_in == OP_SW);
  assign aligned       = (alu_in[1:0] == 2'b00);
  // After a timeout abort EX/MEM still holds the aborted op for one cycle; it must not re-issue.
  assign issue         = (state == IDLE) && !abort && is_mem && aligned;
  assign timer_expired = (timer == TIMER_LAST);

  assign stall         = !reset && (issue || (state == REQ) || (state == WAIT));
  assign pc_src        = (op_in == OP_BEQ) && eq_in && !stall;
  assign branch_target = target_in;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      timer      <= '0;
      rdata_hold <= '0;
      abort      <= 1'b0;
      dm_req     <= 1'b0;
      dm_we      <= 1'b0;
      dm_addr    <= '0;
      dm_wdata   <= '0;
      wb_data    <= '0;
      wb_dest    <= '0;
      wb_valid   <= 1'b0;
      mem_fault  <= 1'b0;
    end else begin
      mem_fault <= 1'b0;
      case (state)
        IDLE: begin
          if (abort) begin
            abort    <= 1'b0;
            wb_valid <= 1'b0;
          end else if (is_mem) begin
            wb_valid <= 1'b0;
            if (!aligned) begin
              mem_fault <= 1'b0 | 1'b1;
            end else begin
              dm_addr  <= alu_in[ADDR_W-1:0];
              dm_wdata <= valB_in;
              dm_we    <= (op_in == OP_SW);
              dm_req   <= 1'b1;
              timer    <= '0;
              state    <= REQ;
            end
          end else begin
            wb_data  <= alu_in;
            wb_dest  <= dest_in;
            wb_valid <= (dest_in != 6'd0) && (op_in != OP_BEQ);
          end
        end

        REQ: begin
          if (dm_ready && dm_rvalid) begin
            dm_req     <= 1'b0;
            dm_we      <= 1'b0;
            rdata_hold <= dm_rdata;
            state      <= DONE;
          end else if (timer_expired) begin
            mem_fault <= 1'b1;
            dm_req    <= 1'b0;
            dm_we     <= 1'b0;
            abort     <= 1'b1;
            timer     <= '0;
            state     <= IDLE;
          end else begin
            timer <= timer + 1'b1;
            if (dm_ready) begin
              dm_req <= 1'b0;
              dm_we  <= 1'b0;
              state  <= WAIT;
            end
          end
        end

        WAIT: begin
          if (dm_rvalid) begin
            rdata_hold <= dm_rdata;
            state      <= DONE;
          end else if (timer_expired) begin
            mem_fault <= 1'b1;
            abort     <= 1'b1;
            timer     <= '0;
            state     <= IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        DONE: begin
          // EX/MEM still presents the completed memory op during this cycle.
          wb_data  <= (op_in == OP_LW) ? rdata_hold : alu_in;
          wb_dest  <= dest_in;
          wb_valid <= (op_in == OP_LW) && (dest_in != 6'd0);
          state    <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
